// File: rtl/mram_bus_sequencer_if.sv
// Signal bundle between the two requesters, the MRAM sequencer and the pad ring.
// The sequencer connects through slave; requesters and pads connect through master.
interface mram_bus_sequencer_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
);
   logic              req0_valid, req0_ready, req0_we, req0_last;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_wdata;
   logic [1:0]        req0_be;
   logic              req1_valid, req1_ready, req1_we, req1_last;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_wdata;
   logic [1:0]        req1_be;
   logic              rd_valid, rd_id;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] addr_line;
   logic [DATA_W-1:0] data_out, data_in;
   logic              data_oe;
   logic              chip_en_out, read_en_out, write_en_out, lb_en_out, ub_en_out;

   modport slave (
      input  req0_valid, req0_we, req0_last, req0_addr, req0_wdata, req0_be,
      input  req1_valid, req1_we, req1_last, req1_addr, req1_wdata, req1_be,
      input  data_in,
      output req0_ready, req1_ready, rd_valid, rd_id, rd_data,
      output addr_line, data_out, data_oe,
      output chip_en_out, read_en_out, write_en_out, lb_en_out, ub_en_out
   );

   modport master (
      output req0_valid, req0_we, req0_last, req0_addr, req0_wdata, req0_be,
      output req1_valid, req1_we, req1_last, req1_addr, req1_wdata, req1_be,
      output data_in,
      input  req0_ready, req1_ready, rd_valid, rd_id, rd_data,
      input  addr_line, data_out, data_oe,
      input  chip_en_out, read_en_out, write_en_out, lb_en_out, ub_en_out
   );
endinterface

// File: rtl/mram_bus_sequencer.sv
// Two-port round-robin sequencer for the shared MRAM bus: setup / strobe / hold
// timing per beat, with the grant locked to one port across a multi-beat burst.
module mram_bus_sequencer #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16,
   parameter int WR_CYC = 4,
   parameter int RD_CYC = 4
) (
   input  logic                FPGA_clk,
   input  logic                FPGA_rst,
   mram_bus_sequencer_if.slave bus
);
   localparam int MAX_CYC = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYC - 1);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYC - 1);

   typedef enum logic [2:0] {IDLE, SETUP, WRITE, READ, HOLD} state_t;

   state_t            state_reg, state_next;
   logic [1:0]        valid, grant;
   logic              sel, accept;
   logic [CNT_W-1:0]  cnt_reg;
   logic              we_reg, port_reg, lock_on_reg, lock_port_reg, rr_favour_reg, rd_id_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [DATA_W-1:0] wdata_reg, rd_data_reg;
   logic [1:0]        be_reg;
   logic              ce, re, wr, oe, rv;

   assign valid = {bus.req1_valid, bus.req0_valid};

   // Grants are only offered from IDLE or HOLD; a lock restricts the choice to the burst owner.
   always_comb begin
      grant = 2'b00;
      if (state_reg == IDLE || state_reg == HOLD) begin
         if (lock_on_reg)
            grant[lock_port_reg] = valid[lock_port_reg];
         else if (valid == 2'b11)
            grant[rr_favour_reg] = 1'b1;
         else
            grant = valid;
      end
   end

   assign accept         = |grant;
   assign sel            = grant[1];
   assign bus.req0_ready = grant[0];
   assign bus.req1_ready = grant[1];

   always_ff @(posedge FPGA_clk or posedge FPGA_rst) begin
      if (FPGA_rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      ce = 1'b0;
      re = 1'b0;
      wr = 1'b0;
      oe = 1'b0;
      rv = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept)
               state_next = SETUP;
         end
         SETUP: begin
            ce = 1'b1;
            oe = we_reg;
            state_next = we_reg ? WRITE : READ;
         end
         WRITE: begin
            ce = 1'b1;
            oe = 1'b1;
            wr = |be_reg;
            if (cnt_reg == '0)
               state_next = HOLD;
         end
         READ: begin
            ce = 1'b1;
            re = 1'b1;
            if (cnt_reg == '0)
               state_next = HOLD;
         end
         HOLD: begin
            ce = 1'b1;
            oe = we_reg;
            rv = ~we_reg;
            state_next = accept ? SETUP : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge FPGA_clk or posedge FPGA_rst) begin
      if (FPGA_rst) begin
         cnt_reg       <= '0;
         we_reg        <= 1'b0;
         port_reg      <= 1'b0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         be_reg        <= 2'b00;
         lock_on_reg   <= 1'b0;
         lock_port_reg <= 1'b0;
         rr_favour_reg <= 1'b0;
         rd_data_reg   <= '0;
         rd_id_reg     <= 1'b0;
      end else begin
         if (accept) begin
            we_reg        <= sel ? bus.req1_we    : bus.req0_we;
            addr_reg      <= sel ? bus.req1_addr  : bus.req0_addr;
            wdata_reg     <= sel ? bus.req1_wdata : bus.req0_wdata;
            be_reg        <= sel ? bus.req1_be    : bus.req0_be;
            port_reg      <= sel;
            rr_favour_reg <= ~sel;
            lock_on_reg   <= ~(sel ? bus.req1_last : bus.req0_last);
            lock_port_reg <= sel;
         end
         if (state_reg == SETUP)
            cnt_reg <= we_reg ? WR_LOAD : RD_LOAD;
         else if ((state_reg == WRITE || state_reg == READ) && cnt_reg != '0)
            cnt_reg <= cnt_reg - CNT_W'(1);
         // Pad data is captured on the edge that ends the last read-strobe cycle.
         if (state_reg == READ && cnt_reg == '0) begin
            rd_data_reg <= bus.data_in;
            rd_id_reg   <= port_reg;
         end
      end
   end

   assign bus.addr_line    = addr_reg;
   assign bus.data_out     = wdata_reg;
   assign bus.data_oe      = oe;
   assign bus.chip_en_out  = ce;
   assign bus.read_en_out  = re;
   assign bus.write_en_out = wr;
   assign bus.lb_en_out    = ce & be_reg[0];
   assign bus.ub_en_out    = ce & be_reg[1];
   assign bus.rd_valid     = rv;
   assign bus.rd_id        = rd_id_reg;
   assign bus.rd_data      = rd_data_reg;
endmodule

// File: tb/tb_mram_bus_sequencer.sv
// Randomized two-port traffic against a beat-level timing model of the MRAM sequencer,
// plus an asynchronous reset that aborts a write mid-strobe.
module tb_mram_bus_sequencer;
   localparam int ADDR_W = 20;
   localparam int DATA_W = 16;
   localparam int WR_CYC = 4;
   localparam int RD_CYC = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mram_bus_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

   mram_bus_sequencer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_CYC(WR_CYC), .RD_CYC(RD_CYC)
   ) dut (
      .FPGA_clk(clk),
      .FPGA_rst(rst),
      .bus(bus)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Requester drivers
   bit                drv_valid[2];
   bit                drv_we[2];
   bit                drv_last[2];
   logic [ADDR_W-1:0] drv_addr[2];
   logic [DATA_W-1:0] drv_wdata[2];
   logic [1:0]        drv_be[2];
   int                burst_left[2];
   logic [DATA_W-1:0] drv_din;
   int                pct;

   // Beat-level reference: the beat on the bus is described by its accept cycle and fields
   bit                cur_active;
   int                cur_c;
   bit                cur_we, cur_port;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_wdata;
   logic [1:0]        cur_be;
   int                lock_port;
   int                favour;
   logic [DATA_W-1:0] exp_rd_data;
   int                grant_m;
   int                cyc = 0;
   int                beats = 0;

   task automatic push_inputs();
      bus.req0_valid = drv_valid[0];
      bus.req0_we    = drv_we[0];
      bus.req0_last  = drv_last[0];
      bus.req0_addr  = drv_addr[0];
      bus.req0_wdata = drv_wdata[0];
      bus.req0_be    = drv_be[0];
      bus.req1_valid = drv_valid[1];
      bus.req1_we    = drv_we[1];
      bus.req1_last  = drv_last[1];
      bus.req1_addr  = drv_addr[1];
      bus.req1_wdata = drv_wdata[1];
      bus.req1_be    = drv_be[1];
      bus.data_in    = drv_din;
   endtask

   task automatic clear_drivers();
      for (int p = 0; p < 2; p++) begin
         drv_valid[p]  = 1'b0;
         drv_we[p]     = 1'b0;
         drv_last[p]   = 1'b0;
         drv_addr[p]   = '0;
         drv_wdata[p]  = '0;
         drv_be[p]     = 2'b00;
         burst_left[p] = 0;
      end
      drv_din = '0;
   endtask

   task automatic model_reset();
      cur_active  = 1'b0;
      cur_c       = 0;
      cur_we      = 1'b0;
      cur_port    = 1'b0;
      cur_addr    = '0;
      cur_wdata   = '0;
      cur_be      = 2'b00;
      lock_port   = -1;
      favour      = 0;
      exp_rd_data = '0;
      grant_m     = -1;
   endtask

   task automatic check_quiet(input string pfx);
      check({pfx, "_chip_en"},  bus.chip_en_out,  1'b0);
      check({pfx, "_write_en"}, bus.write_en_out, 1'b0);
      check({pfx, "_read_en"},  bus.read_en_out,  1'b0);
      check({pfx, "_data_oe"},  bus.data_oe,      1'b0);
      check({pfx, "_rd_valid"}, bus.rd_valid,     1'b0);
   endtask

   // Evaluated at the falling edge: compare outputs of this cycle, then decide this cycle's grant.
   task automatic tick_check();
      int len, k;
      bit in_win, strobe, free;
      @(negedge clk);
      len    = cur_we ? WR_CYC : RD_CYC;
      k      = cyc - cur_c;
      in_win = cur_active && k >= 1 && k <= len + 2;
      strobe = in_win && k >= 2 && k <= len + 1;
      check("chip_en",  bus.chip_en_out,  in_win);
      check("lb_en",    bus.lb_en_out,    in_win && cur_be[0]);
      check("ub_en",    bus.ub_en_out,    in_win && cur_be[1]);
      check("write_en", bus.write_en_out, strobe && cur_we && cur_be != 2'b00);
      check("read_en",  bus.read_en_out,  strobe && !cur_we);
      check("data_oe",  bus.data_oe,      in_win && cur_we);
      check("rd_valid", bus.rd_valid,     in_win && !cur_we && k == len + 2);
      if (in_win)
         check("addr_line", bus.addr_line, cur_addr);
      if (in_win && cur_we)
         check("data_out", bus.data_out, cur_wdata);
      if (in_win && !cur_we && k == len + 2)
         check("rd_id", bus.rd_id, cur_port);
      check("rd_data", bus.rd_data, exp_rd_data);
      if (in_win && !cur_we && k == len + 1)
         exp_rd_data = drv_din;

      free    = !cur_active || k >= len + 2;
      grant_m = -1;
      if (free) begin
         if (lock_port >= 0) begin
            if (drv_valid[lock_port]) grant_m = lock_port;
         end else if (drv_valid[0] && drv_valid[1]) begin
            grant_m = favour;
         end else if (drv_valid[0]) begin
            grant_m = 0;
         end else if (drv_valid[1]) begin
            grant_m = 1;
         end
      end
      check("ready0", bus.req0_ready, grant_m == 0);
      check("ready1", bus.req1_ready, grant_m == 1);
      if (grant_m >= 0) begin
         cur_active = 1'b1;
         cur_c      = cyc;
         cur_we     = drv_we[grant_m];
         cur_port   = (grant_m == 1);
         cur_addr   = drv_addr[grant_m];
         cur_wdata  = drv_wdata[grant_m];
         cur_be     = drv_be[grant_m];
         favour     = 1 - grant_m;
         lock_port  = drv_last[grant_m] ? -1 : grant_m;
         beats++;
         $display("beat %0d: port %0d %s addr %05h wdata %04h be %b last %0b", beats, grant_m,
                  cur_we ? "WR" : "RD", cur_addr, cur_wdata, cur_be, drv_last[grant_m]);
      end
   endtask

   task automatic tick_drive();
      @(posedge clk);
      #1;
      cyc++;
      for (int p = 0; p < 2; p++) begin
         if (grant_m == p) begin
            burst_left[p]--;
            drv_valid[p] = 1'b0;
         end
         if (!drv_valid[p]) begin
            if (burst_left[p] == 0 && $urandom_range(99) < pct)
               burst_left[p] = $urandom_range(1, 3);
            if (burst_left[p] > 0 && (pct == 100 || $urandom_range(9) < 8)) begin
               drv_valid[p] = 1'b1;
               drv_we[p]    = 1'($urandom_range(1));
               drv_addr[p]  = ADDR_W'($urandom);
               drv_wdata[p] = DATA_W'($urandom);
               drv_be[p]    = 2'($urandom_range(3));
               drv_last[p]  = (burst_left[p] == 1);
            end
         end
      end
      drv_din = DATA_W'($urandom);
      grant_m = -1;
      push_inputs();
   endtask

   initial begin
      bit found;
      int phase_pct[3];
      phase_pct[0] = 100;
      phase_pct[1] = 50;
      phase_pct[2] = 20;
      pct = 0;
      clear_drivers();
      model_reset();
      push_inputs();
      #1;
      check_quiet("rst");
      check("rst_addr_line", bus.addr_line, 0);
      check("rst_data_out",  bus.data_out,  0);
      check("rst_rd_data",   bus.rd_data,   0);
      check("rst_ready0",    bus.req0_ready, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single write on port 0 that is aborted by reset during its second strobe cycle
      drv_valid[0]  = 1'b1;
      drv_we[0]     = 1'b1;
      drv_addr[0]   = 20'h0AAAA;
      drv_wdata[0]  = 16'h5555;
      drv_be[0]     = 2'b11;
      drv_last[0]   = 1'b1;
      burst_left[0] = 1;
      push_inputs();
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick_check();
         if (cur_active && cyc - cur_c == 3)
            found = 1'b1;
         else
            tick_drive();
      end
      check("abort_reached", found, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_quiet("abort");
      clear_drivers();
      model_reset();
      push_inputs();
      @(posedge clk);
      #1;
      check_quiet("abort_hold");
      check("abort_addr_line", bus.addr_line, 0);
      rst = 1'b0;

      for (int ph = 0; ph < 3; ph++) begin
         pct = phase_pct[ph];
         repeat (200) begin
            tick_check();
            tick_drive();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
